// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and constants.
// Block geometry, state encoding and owner codes.
package mem_arb_pkg;

  localparam int ARB_WORDS   = 8;
  localparam int ARB_LATENCY = 4;
  localparam int BLOCK_OFFSET_BITS = $clog2(ARB_WORDS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL_I,
    FILL_D,
    WRITE
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  function automatic logic [15:0] block_base(
    input logic [15:0] a,
    input int          ob
  );
    return a & ~((16'd1 << ob) - 16'd1);
  endfunction

endpackage

// File: rtl/mem_arb_fill_seq.sv
// Block fill sequencer: issue/return counters,
// word address generation and completion detect.
module mem_arb_fill_seq
  import mem_arb_pkg::*;
#(
  parameter int WORDS = ARB_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_active,
  input  logic [15:0] i_base,
  input  logic        i_mem_valid,
  output logic        o_issue,
  output logic [15:0] o_addr,
  output logic        o_ret_valid,
  output logic        o_last
);

  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [CW-1:0] r_issue_cnt;
  logic [CW-1:0] r_ret_cnt;
  logic          r_issuing;

  assign o_issue     = i_active & r_issuing;
  assign o_addr      = o_issue
                     ? i_base + {{(15-CW){1'b0}}, r_issue_cnt, 1'b0}
                     : 16'h0;
  assign o_ret_valid = i_active & i_mem_valid;
  assign o_last      = o_ret_valid & (r_ret_cnt == LAST);

  // issue counter parks on the last word instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_issuing   <= 1'b0;
    end else if (i_start) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_issuing   <= 1'b1;
    end else begin
      if (o_issue) begin
        if (r_issue_cnt == LAST) r_issuing <= 1'b0;
        else r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (o_ret_valid) r_ret_cnt <= r_ret_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache memory arbiter: block fills and write-through.
// MEM_ARB_RR_EN selects round-robin instead of D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORDS = ARB_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_busy,
  output logic        d_busy,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done
);

  localparam int OB = $clog2(WORDS) + 1;

  arb_state_t  r_state;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;

  logic        w_pick_d;
  logic        w_start;
  logic        w_fill;
  logic        w_issue;
  logic [15:0] w_fill_addr;
  logic        w_ret_valid;
  logic        w_last;

`ifdef MEM_ARB_RR_EN
  logic r_last_own;
  assign w_pick_d = d_req & (~i_req | (r_last_own == OWN_I));
`else
  assign w_pick_d = d_req;
`endif

  assign w_start = (r_state == IDLE) & (w_pick_d ? ~d_wr : i_req);
  assign w_fill  = (r_state == FILL_I) | (r_state == FILL_D);

  mem_arb_fill_seq #(
    .WORDS(WORDS)
  ) u_fill (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_active   (w_fill),
    .i_base     (r_addr),
    .i_mem_valid(mem_data_valid),
    .o_issue    (w_issue),
    .o_addr     (w_fill_addr),
    .o_ret_valid(w_ret_valid),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= 16'h0;
      r_wdata <= 16'h0;
`ifdef MEM_ARB_RR_EN
      r_last_own <= OWN_D;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state <= d_wr ? WRITE : FILL_D;
            r_addr  <= d_wr ? {d_addr[15:1], 1'b0}
                            : block_base(d_addr, OB);
            r_wdata <= d_wr ? d_wdata : 16'h0;
`ifdef MEM_ARB_RR_EN
            r_last_own <= OWN_D;
`endif
          end else if (i_req) begin
            r_state <= FILL_I;
            r_addr  <= block_base(i_addr, OB);
            r_wdata <= 16'h0;
`ifdef MEM_ARB_RR_EN
            r_last_own <= OWN_I;
`endif
          end
        end
        FILL_I, FILL_D: begin
          if (w_last) begin
            r_state <= IDLE;
            r_addr  <= 16'h0;
          end
        end
        WRITE: begin
          r_state <= IDLE;
          r_addr  <= 16'h0;
          r_wdata <= 16'h0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_enable   = (r_state == WRITE) | w_issue;
  assign mem_wr       = (r_state == WRITE);
  assign mem_addr     = (r_state == WRITE) ? r_addr : w_fill_addr;
  assign mem_wdata    = (r_state == WRITE) ? r_wdata : 16'h0;

  assign i_data_valid = w_ret_valid & (r_state == FILL_I);
  assign d_data_valid = w_ret_valid & (r_state == FILL_D);
  assign fill_data    = mem_data_in;

  assign i_done = w_last & (r_state == FILL_I);
  assign d_done = (w_last & (r_state == FILL_D)) | (r_state == WRITE);

  assign i_busy = i_req | (r_state == FILL_I);
  assign d_busy = d_req | (r_state == FILL_D) | (r_state == WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle
// latency memory model returning addr ^ 16'hA5A5.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [15:0] d_wdata = 16'h0;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        i_busy;
  logic        d_busy;
  logic        i_data_valid;
  logic        d_data_valid;
  logic [15:0] fill_data;
  logic        i_done;
  logic        d_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .d_req         (d_req),
    .d_wr          (d_wr),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .mem_data_in   (mem_data_in),
    .mem_data_valid(mem_data_valid),
    .mem_enable    (mem_enable),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .i_busy        (i_busy),
    .d_busy        (d_busy),
    .i_data_valid  (i_data_valid),
    .d_data_valid  (d_data_valid),
    .fill_data     (fill_data),
    .i_done        (i_done),
    .d_done        (d_done)
  );

  // memory model: not reset, so in-flight reads survive a DUT reset
  logic [3:0]  p_v = 4'h0;
  logic [15:0] p_a [0:3] = '{default: 16'h0};

  always @(posedge clk) begin
    p_v    <= {p_v[2:0], mem_enable & ~mem_wr};
    p_a[0] <= mem_addr;
    p_a[1] <= p_a[0];
    p_a[2] <= p_a[1];
    p_a[3] <= p_a[2];
  end

  assign mem_data_valid = p_v[3];
  assign mem_data_in    = p_v[3] ? (p_a[3] ^ 16'hA5A5) : 16'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    n_tests++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, i_busy, d_busy,
         i_data_valid, d_data_valid, fill_data, i_done, d_done} !== '0) begin
      n_fail++;
      $display("FAIL reset en=%b wr=%b addr=%h wd=%h ib=%b db=%b req=all 0",
               mem_enable, mem_wr, mem_addr, mem_wdata, i_busy, d_busy);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_i_fill();
    logic        e_en, e_v, e_dn;
    logic [15:0] e_a, e_d;
    i_addr = 16'h1236;
    i_req  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      e_en = (k <= 8);
      e_a  = e_en ? 16'h1230 + 16'(2 * (k - 1)) : 16'h0;
      e_v  = (k >= 5) && (k <= 12);
      e_d  = e_v ? ((16'h1230 + 16'(2 * (k - 5))) ^ 16'hA5A5) : 16'h0;
      e_dn = (k == 12);
      n_tests++;
      if (mem_enable !== e_en || mem_addr !== e_a || mem_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL ifill_issue k=%0d en=%b addr=%h req en=%b addr=%h",
                 k, mem_enable, mem_addr, e_en, e_a);
      end
      n_tests++;
      if (i_data_valid !== e_v || fill_data !== e_d) begin
        n_fail++;
        $display("FAIL ifill_data k=%0d v=%b d=%h req v=%b d=%h",
                 k, i_data_valid, fill_data, e_v, e_d);
      end
      n_tests++;
      if (i_done !== e_dn || i_busy !== (k <= 12)) begin
        n_fail++;
        $display("FAIL ifill_done k=%0d done=%b busy=%b req done=%b",
                 k, i_done, i_busy, e_dn);
      end
      n_tests++;
      if ({d_data_valid, d_done, d_busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL ifill_dquiet k=%0d dv=%b dd=%b db=%b req 000",
                 k, d_data_valid, d_done, d_busy);
      end
      if (k == 12) i_req = 1'b0;
    end
  endtask

  task automatic test_priority();
    logic        e_en, e_iv, e_dv;
    logic [15:0] e_a;
    i_addr = 16'h3000;
    d_addr = 16'h2008;
    d_wr   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      e_en = (k <= 8) || (k >= 14 && k <= 21);
      e_a  = (k <= 8) ? 16'h2000 + 16'(2 * (k - 1))
           : e_en ? 16'h3000 + 16'(2 * (k - 14)) : 16'h0;
      e_dv = (k >= 5) && (k <= 12);
      e_iv = (k >= 18) && (k <= 25);
      n_tests++;
      if (mem_enable !== e_en || mem_addr !== e_a) begin
        n_fail++;
        $display("FAIL prio_issue k=%0d en=%b addr=%h req en=%b addr=%h",
                 k, mem_enable, mem_addr, e_en, e_a);
      end
      n_tests++;
      if (d_data_valid !== e_dv || i_data_valid !== e_iv) begin
        n_fail++;
        $display("FAIL prio_valid k=%0d dv=%b iv=%b req dv=%b iv=%b",
                 k, d_data_valid, i_data_valid, e_dv, e_iv);
      end
      n_tests++;
      if (d_done !== (k == 12) || i_done !== (k == 25)) begin
        n_fail++;
        $display("FAIL prio_done k=%0d dd=%b id=%b", k, d_done, i_done);
      end
      if (k == 5) begin
        n_tests++;
        if (fill_data !== (16'h2000 ^ 16'hA5A5)) begin
          n_fail++;
          $display("FAIL prio_dword0 data=%h req=%h",
                   fill_data, 16'h2000 ^ 16'hA5A5);
        end
      end
      if (k == 12) d_req = 1'b0;
      if (k == 25) i_req = 1'b0;
    end
  endtask

  task automatic test_write();
    d_addr  = 16'h4001;
    d_wdata = 16'hBEEF;
    d_wr    = 1'b1;
    d_req   = 1'b1;
    step();
    n_tests++;
    if (mem_enable !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h4000 ||
        mem_wdata !== 16'hBEEF || d_done !== 1'b1) begin
      n_fail++;
      $display("FAIL write en=%b wr=%b addr=%h wd=%h dd=%b req 1 1 4000 beef 1",
               mem_enable, mem_wr, mem_addr, mem_wdata, d_done);
    end
    d_req = 1'b0;
    d_wr  = 1'b0;
    step();
    n_tests++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, d_done, d_busy} !== '0) begin
      n_fail++;
      $display("FAIL write_idle en=%b wr=%b addr=%h wd=%h dd=%b db=%b req 0",
               mem_enable, mem_wr, mem_addr, mem_wdata, d_done, d_busy);
    end
  endtask

  task automatic test_write_during_fill();
    i_addr = 16'h1000;
    i_req  = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k >= 3 && k <= 13) begin
        n_tests++;
        if (d_busy !== 1'b1 || mem_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL wdf_hold k=%0d db=%b wr=%b req db=1 wr=0",
                   k, d_busy, mem_wr);
        end
      end
      if (k == 12) begin
        n_tests++;
        if (i_done !== 1'b1) begin
          n_fail++;
          $display("FAIL wdf_idone done=%b req=1", i_done);
        end
        i_req = 1'b0;
      end
      if (k == 13) begin
        n_tests++;
        if (mem_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL wdf_gap en=%b req=0", mem_enable);
        end
      end
      if (k == 14) begin
        n_tests++;
        if (mem_wr !== 1'b1 || mem_addr !== 16'h5002 ||
            mem_wdata !== 16'h1234 || d_done !== 1'b1) begin
          n_fail++;
          $display("FAIL wdf_write wr=%b addr=%h wd=%h dd=%b req 1 5002 1234 1",
                   mem_wr, mem_addr, mem_wdata, d_done);
        end
        d_req = 1'b0;
        d_wr  = 1'b0;
      end
      if (k == 15) begin
        n_tests++;
        if (mem_enable !== 1'b0 || d_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL wdf_after en=%b db=%b req 0 0", mem_enable, d_busy);
        end
      end
      if (k == 2) begin
        d_addr  = 16'h5003;
        d_wdata = 16'h1234;
        d_wr    = 1'b1;
        d_req   = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int nv = 0;
    int nd = 0;
    i_addr = 16'h7000;
    i_req  = 1'b1;
    for (int k = 1; k <= 3; k++) step();
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    n_tests++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata, i_busy, d_busy,
         i_data_valid, d_data_valid, i_done, d_done} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async en=%b addr=%h ib=%b iv=%b req all 0",
               mem_enable, mem_addr, i_busy, i_data_valid);
    end
    step();
    n_tests++;
    if ({mem_enable, mem_addr, i_busy, i_data_valid} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_held en=%b addr=%h ib=%b req 0",
               mem_enable, mem_addr, i_busy);
    end
    rst_n = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      step();
      n_tests++;
      if (i_data_valid !== 1'b0 || mem_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale k=%0d iv=%b en=%b req 0 0",
                 k, i_data_valid, mem_enable);
      end
    end
    i_addr = 16'h0010;
    i_req  = 1'b1;
    for (int k = 8; k <= 20; k++) begin
      step();
      if (k == 8) begin
        n_tests++;
        if (mem_enable !== 1'b1 || mem_addr !== 16'h0010) begin
          n_fail++;
          $display("FAIL rstmid_new en=%b addr=%h req 1 0010",
                   mem_enable, mem_addr);
        end
      end
      if (i_data_valid) nv++;
      if (i_done) begin
        nd++;
        n_tests++;
        if (k != 19) begin
          n_fail++;
          $display("FAIL rstmid_done_cycle k=%0d req=19", k);
        end
        i_req = 1'b0;
      end
    end
    n_tests++;
    if (nv != 8 || nd != 1) begin
      n_fail++;
      $display("FAIL rstmid_count words=%0d done=%0d req 8 1", nv, nd);
    end
  endtask

  task automatic test_drop_mid_fill();
    int nv = 0;
    int nd = 0;
    i_addr = 16'hABCD;
    i_req  = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1 || k == 8) begin
        n_tests++;
        if (mem_addr !== (k == 1 ? 16'hABC0 : 16'hABCE)) begin
          n_fail++;
          $display("FAIL drop_addr k=%0d addr=%h", k, mem_addr);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (i_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_busy busy=%b req=1", i_busy);
        end
      end
      if (i_data_valid) nv++;
      if (i_done) nd++;
      if (k == 2) i_req = 1'b0;
    end
    n_tests++;
    if (nv != 8 || nd != 1 || i_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_count words=%0d done=%0d busy=%b req 8 1 0",
               nv, nd, i_busy);
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_priority();
    test_write();
    test_write_during_fill();
    test_reset_mid_fill();
    test_drop_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
